// File: rtl/mmio_io_regs_pkg.sv
// mmio_io_regs_pkg: MMIO address map, TX FSM encodings and writeback select codes.
package mmio_io_regs_pkg;
    localparam logic [31:0] MMIO_UART_CTRL = 32'h8000_0000;
    localparam logic [31:0] MMIO_UART_RX   = 32'h8000_0004;
    localparam logic [31:0] MMIO_UART_TX   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CYC_CNT   = 32'h8000_0010;
    localparam logic [31:0] MMIO_INST_CNT  = 32'h8000_0014;
    localparam logic [31:0] MMIO_CNT_CLR   = 32'h8000_0018;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;
    localparam logic [1:0] CONV_NONE = 2'b00;
    localparam logic [1:0] CONV_READ = 2'b01;
    function automatic logic is_mmio(input logic [31:0] a);
        return a[31];
    endfunction
endpackage

// File: rtl/mmio_io_regs_io_counter.sv
// io_counter: W-bit free-running counter with enable and clear; clear wins over enable.
module io_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst || clr) count <= '0;
        else if (en) count <= count + 1'b1;
    end
endmodule

// File: rtl/mmio_io_regs.sv
// mmio_io_regs: MMIO decode for UART handshakes and perf counters, with
// one-cycle registered read data aligned to synchronous DMEM/BIOS reads.
module mmio_io_regs
    import mmio_io_regs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retire,
    input  logic [7:0]  rx_data_out,
    input  logic        rx_data_out_valid,
    output logic        rx_data_out_ready,
    output logic [7:0]  tx_data_in,
    output logic        tx_data_in_valid,
    input  logic        tx_data_in_ready,
    output logic [31:0] uart_data_o,
    output logic [1:0]  control_uart_o
);
    logic [0:0] state;
    logic [CNT_W-1:0] cyc_cnt, inst_cnt;
    logic [31:0] rdata;
    logic st, tx_busy, tx_ready, cnt_clr;
    logic unused_wdata;

    // A simultaneous load wins: the store half is discarded.
    assign st = we & ~re;
    assign tx_busy = state == TX_SEND;
    assign tx_ready = tx_data_in_ready & ~tx_busy;
    assign tx_data_in_valid = tx_busy;
    assign cnt_clr = st & (addr == MMIO_CNT_CLR);
    assign rx_data_out_ready = rst & re & (addr == MMIO_UART_RX) & rx_data_out_valid;
    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        rdata = (addr == MMIO_UART_CTRL) ? {30'b0, rx_data_out_valid, tx_ready} :
                (addr == MMIO_UART_RX)   ? {24'b0, rx_data_out_valid ? rx_data_out : 8'h00} :
                (addr == MMIO_CYC_CNT)   ? 32'(cyc_cnt) :
                (addr == MMIO_INST_CNT)  ? 32'(inst_cnt) : 32'h0;
    end

    // Stores arriving while a byte is in flight are dropped; software polls ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= TX_IDLE;
            tx_data_in <= 8'h00;
        end else if (!tx_busy && st && addr == MMIO_UART_TX) begin
            state <= TX_SEND;
            tx_data_in <= wdata[7:0];
        end else if (tx_busy && tx_data_in_ready) begin
            state <= TX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            uart_data_o <= 32'h0;
            control_uart_o <= CONV_NONE;
        end else begin
            if (re) uart_data_o <= rdata;
            control_uart_o <= (re && is_mmio(addr)) ? CONV_READ : CONV_NONE;
        end
    end

    io_counter #(.W(CNT_W)) u_cyc (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .clr   (cnt_clr),
        .count (cyc_cnt)
    );

    io_counter #(.W(CNT_W)) u_inst (
        .clk   (clk),
        .rst   (rst),
        .en    (inst_retire),
        .clr   (cnt_clr),
        .count (inst_cnt)
    );
endmodule

// File: tb/tb_mmio_io_regs.sv
// tb_mmio_io_regs: table-driven and scoreboarded checks of mmio_io_regs at
// CNT_W=32 and a CNT_W=4 instance sharing the same stimulus for wrap checks.
module tb_mmio_io_regs;
    localparam logic [31:0] A_CTRL = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INST = 32'h8000_0014;
    localparam logic [31:0] A_CLR  = 32'h8000_0018;

    logic clk = 1'b0;
    logic rst, we, re, inst_retire, rx_valid, tx_rdy_in;
    logic [31:0] addr, wdata;
    logic [7:0] rx_data;
    logic rx_rdy, tx_valid, rx_rdy4, tx_valid4;
    logic [7:0] tx_data, tx_data4;
    logic [31:0] udata, udata4;
    logic [1:0] ctrl, ctrl4;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic [31:0] ed;
        logic        ep;
        string       nm;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] d4;
        logic [1:0]  c;
        string       nm;
    } exp_t;

    vec_t tbl[10];
    exp_t sb[$];

    always #5 clk = ~clk;

    mmio_io_regs #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retire(inst_retire), .rx_data_out(rx_data), .rx_data_out_valid(rx_valid),
        .rx_data_out_ready(rx_rdy), .tx_data_in(tx_data), .tx_data_in_valid(tx_valid),
        .tx_data_in_ready(tx_rdy_in), .uart_data_o(udata), .control_uart_o(ctrl)
    );

    mmio_io_regs #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .inst_retire(inst_retire), .rx_data_out(rx_data), .rx_data_out_valid(rx_valid),
        .rx_data_out_ready(rx_rdy4), .tx_data_in(tx_data4), .tx_data_in_valid(tx_valid4),
        .tx_data_in_ready(tx_rdy_in), .uart_data_o(udata4), .control_uart_o(ctrl4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk();
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: got empty queue, expected a pending load");
        end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_data"}, udata, e.d);
            chk({e.nm, "_data4"}, udata4, e.d4);
            chk({e.nm, "_ctrl"}, 32'(ctrl), 32'(e.c));
        end
    endtask

    task automatic op(input logic [31:0] a, input logic w, input logic r, input logic [31:0] wd,
                      input logic ret, input logic [31:0] e, input logic [31:0] e4, input string nm);
        addr = a; we = w; re = r; wdata = wd; inst_retire = ret;
        if (r) sb.push_back('{d: e, d4: e4, c: {1'b0, a[31]}, nm: nm});
        tick();
        addr = '0; we = 1'b0; re = 1'b0; wdata = '0; inst_retire = 1'b0;
        if (r) pop_chk();
    endtask

    initial begin
        logic [11:0] pat;
        pat = 12'b1010_1101_0110;
        tbl[0] = '{A_CTRL, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0, "st_00"};
        tbl[1] = '{A_CTRL, 1'b0, 8'h00, 1'b1, 32'h1, 1'b0, "st_01"};
        tbl[2] = '{A_CTRL, 1'b1, 8'h11, 1'b0, 32'h2, 1'b0, "st_10"};
        tbl[3] = '{A_CTRL, 1'b1, 8'h11, 1'b1, 32'h3, 1'b0, "st_11"};
        tbl[4] = '{A_RX,   1'b1, 8'h5A, 1'b0, 32'h5A, 1'b1, "rx_valid"};
        tbl[5] = '{A_RX,   1'b0, 8'h77, 1'b0, 32'h0, 1'b0, "rx_empty"};
        tbl[6] = '{32'h8000_0020, 1'b1, 8'h5A, 1'b1, 32'h0, 1'b0, "unmapped"};
        tbl[7] = '{A_TX,   1'b1, 8'h5A, 1'b1, 32'h0, 1'b0, "rd_tx"};
        tbl[8] = '{32'h0000_0004, 1'b1, 8'h5A, 1'b1, 32'h0, 1'b0, "non_mmio"};
        tbl[9] = '{32'h8000_0005, 1'b1, 8'h5A, 1'b1, 32'h0, 1'b0, "misalign"};

        rst = 1'b0; we = 1'b0; re = 1'b1; inst_retire = 1'b0; wdata = '0;
        addr = A_RX; rx_valid = 1'b1; rx_data = 8'hA5; tx_rdy_in = 1'b0;
        tick();
        tick();
        chk("rst_rx_rdy", rx_rdy, 0);
        chk("rst_udata", udata, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        rst = 1'b1; re = 1'b0; addr = '0; rx_valid = 1'b0;

        repeat (10) tick();
        op(A_CYC, 0, 1, 0, 0, 10, 10, "cyc10");
        tick();
        chk("ctrl_drop", ctrl, 0);
        chk("udata_hold", udata, 10);

        foreach (tbl[i]) begin
            addr = tbl[i].a; re = 1'b1; rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd; tx_rdy_in = tbl[i].txr;
            sb.push_back('{d: tbl[i].ed, d4: tbl[i].ed, c: {1'b0, tbl[i].a[31]}, nm: tbl[i].nm});
            #1;
            chk({tbl[i].nm, "_pulse"}, rx_rdy, tbl[i].ep);
            tick();
            re = 1'b0; addr = '0;
            #1;
            chk({tbl[i].nm, "_pulse_off"}, rx_rdy, 0);
            pop_chk();
        end
        rx_valid = 1'b0; tx_rdy_in = 1'b0;

        op(A_TX, 1, 0, 32'h41, 0, 0, 0, "st41");
        chk("tx41_valid", tx_valid, 1);
        chk("tx41_data", tx_data, 8'h41);
        op(A_TX, 1, 0, 32'h42, 0, 0, 0, "st42");
        chk("tx42_drop", tx_data, 8'h41);
        tick();
        chk("tx41_hold_valid", tx_valid, 1);
        chk("tx41_hold_data", tx_data, 8'h41);
        op(A_CTRL, 0, 1, 0, 0, 0, 0, "st_busy");
        tx_rdy_in = 1'b1;
        op(A_CTRL, 0, 1, 0, 0, 0, 0, "st_busy_hs");
        chk("tx_done_valid", tx_valid, 0);
        op(A_CTRL, 0, 1, 0, 0, 1, 1, "st_idle");
        tx_rdy_in = 1'b0;
        op(A_TX, 1, 0, 32'h43, 0, 0, 0, "st43");
        chk("tx43_data", tx_data, 8'h43);
        tx_rdy_in = 1'b1;
        op(A_TX, 1, 0, 32'h44, 0, 0, 0, "st44_hs");
        chk("tx44_valid", tx_valid, 0);
        chk("tx44_drop", tx_data, 8'h43);
        op(A_TX, 1, 0, 32'h45, 0, 0, 0, "st45");
        chk("tx45_valid", tx_valid, 1);
        chk("tx45_data", tx_data, 8'h45);
        tick();
        chk("tx45_done", tx_valid, 0);
        op(A_TX, 1, 1, 32'h66, 0, 0, 0, "we_re");
        chk("we_re_valid", tx_valid, 0);
        tx_rdy_in = 1'b0;

        op(A_CLR, 1, 0, 0, 0, 0, 0, "clr0");
        for (int i = 0; i < 12; i++) op(32'h0, 0, 0, 0, pat[11-i], 0, 0, "ret");
        op(A_INST, 0, 1, 0, 0, 7, 7, "inst7");
        op(A_CYC, 0, 1, 0, 0, 13, 13, "cyc13");
        op(A_CLR, 1, 0, 0, 1, 0, 0, "clr_ret");
        op(A_INST, 0, 1, 0, 0, 0, 0, "inst_clr");
        op(A_CYC, 0, 1, 0, 0, 1, 1, "cyc_clr");

        op(A_CLR, 1, 0, 0, 0, 0, 0, "clr1");
        repeat (14) tick();
        for (int i = 0; i < 4; i++) op(A_CYC, 0, 1, 0, 0, 14 + i, (14 + i) % 16, "wrap");

        op(A_TX, 1, 0, 32'h55, 0, 0, 0, "st55");
        chk("tx55_valid", tx_valid, 1);
        rst = 1'b0;
        tick();
        chk("rst_send_valid", tx_valid, 0);
        chk("rst_send_data", tx_data, 0);
        chk("rst_send_udata", udata, 0);
        chk("rst_send_udata4", udata4, 0);
        chk("rst_send_ctrl", ctrl, 0);
        rst = 1'b1;
        op(A_CYC, 0, 1, 0, 0, 0, 0, "cyc_post_rst");
        op(A_CYC, 0, 1, 0, 0, 1, 1, "cyc_post_rst1");
        op(A_INST, 0, 1, 0, 0, 0, 0, "inst_post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_io_regs.md
# mmio_io_regs

Memory-mapped I/O register block for the RISC-V core's 0x8000_00xx region. It decodes load/store addresses from the memory stage and drives the UART ready/valid handshakes. It keeps the cycle and retired-instruction counters. Its registered read data and select code feed the writeback data mux (`uart_data_i`, `control_uart_i`) one cycle after the access, aligned with synchronous DMEM/BIOS reads.

## Interface
Parameters:
- CNT_W, 32, width of both performance counters (≤32; read value zero-extended).

Ports:
- clk  in  1  core clock; the block uses one clock.
- rst  in  1  reset, synchronous and active-low: asserted (low) at a rising edge → all state takes its reset value.
- addr  in  32  memory-stage effective address.
- wdata  in  32  store data.
- we  in  1  store strobe this cycle (already qualified by stall/flush).
- re  in  1  load strobe this cycle (already qualified).
- inst_retire  in  1  one valid instruction retires this cycle.
- rx_data_out  in  8  UART receive byte.
- rx_data_out_valid  in  1  receive byte available.
- rx_data_out_ready  out  1  pop receive byte (1-cycle pulse).
- tx_data_in  out  8  transmit byte.
- tx_data_in_valid  out  1  transmit byte valid.
- tx_data_in_ready  in  1  UART transmitter can accept.
- uart_data_o  out  32  read data, registered.
- control_uart_o  out  2  2'b01 = previous cycle was an MMIO load, 2'b00 otherwise.

## Operation
Address map (exact 32-bit match; other 0x8xxx_xxxx addresses read 0, writes ignored):
- 0x8000_0000 R: {30'b0, rx_data_out_valid, tx_ready}; tx_ready = tx_data_in_ready & ~tx_busy.
- 0x8000_0004 R: {24'b0, rx_data_out}; if rx_data_out_valid, pulse rx_data_out_ready this same cycle. A read with valid low returns 0 and does not pulse.
- 0x8000_0008 W: transmit wdata[7:0].
- 0x8000_0010 R: cycle counter. 0x8000_0014 R: retired-instruction counter.
- 0x8000_0018 W: clear both counters (data ignored).

TX FSM, states IDLE and SEND:
- IDLE with a store to 0x08 → latch byte, go to SEND.
- SEND: tx_data_in_valid = 1; on tx_data_in_ready → IDLE.
- tx_busy = (state == SEND).
- A store to 0x08 while in SEND is dropped. Software polls bit 0.
- A store and the completing handshake in the same cycle: the store is dropped, and the FSM returns to IDLE.

Counters:
- The cycle counter increments every cycle out of reset.
- The instruction counter increments when inst_retire is high.
- Both wrap modulo 2^CNT_W.
- Clear has priority over increment: after the clear edge, the counter value is 0.

Loads and stores:
- re and we are never both high. If they are, the store is ignored.
- A load to 0x8xxx_xxxx (addr[31]=1) sets control_uart_o = 01 next cycle. Otherwise control_uart_o = 00.

## Timing
- Read latency is 1. A load in cycle N samples state as held during N (pre-increment counter value). Data appears on uart_data_o in cycle N+1.
- uart_data_o holds its value until the next load.
- rx_data_out_ready is combinational from addr/re/rx_data_out_valid, high only in cycle N.
- A store to 0x08 in cycle N gives tx_data_in_valid high from N+1.
- Reset values: uart_data_o = 0, control_uart_o = 00, tx_data_in = 0, tx_data_in_valid = 0, FSM = IDLE, both counters = 0. rx_data_out_ready is 0 during reset.
- Reset mid-SEND: tx_data_in_valid drops the next cycle and the byte is lost. A counter is 0 on the first cycle after reset, then counts.

## Structure
- The address constants MMIO_UART_CTRL, MMIO_UART_RX, MMIO_UART_TX, MMIO_CYC_CNT, MMIO_INST_CNT and MMIO_CNT_CLR go in defines.vh beside CONV_READ.
- The TX state encodings go in defines.vh.
- One sub-module: io_counter (CNT_W-bit enable/clear/wrap counter), instantiated twice.
- State registers use the codebase REGISTER_R family where practical.

## Test plan
- Reset, then 10 idle cycles, then a load 0x8000_0010 → uart_data_o = 10 (±pipeline offset checked exactly), control_uart_o = 01 for one cycle.
- Store 0x41 to 0x8000_0008 with tx_data_in_ready = 0 for 3 cycles → valid high and tx_data_in = 0x41 held. A second store of 0x42 meanwhile is dropped. Raise ready → valid low next cycle, and bit 0 of 0x8000_0000 reads 1.
- rx_data_out_valid = 1 with rx_data_out = 0x5A, then load 0x8000_0004 → one-cycle ready pulse, uart_data_o = 0x0000_005A. Load with valid = 0 → 0 and no pulse.
- inst_retire on 7 of 12 cycles, then load 0x8000_0014 → 7. Store to 0x8000_0018 in the same cycle as inst_retire → both counters 0 after the edge.
- Preload the counter near the wrap point (CNT_W = 4 build): counts 14, 15, 0, 1. A load to 0x8000_0020 → 0, with control_uart_o = 01.
- Assert rst low during SEND → tx_data_in_valid = 0, uart_data_o = 0, and counters = 0 on the following cycle.
